// File: rtl/hs32_wb_master.sv
// Wishbone classic master: one request at a time, response pulse on ack.
// Optional bus timeout enabled by defining HS32_WBM_TIMEOUT_EN.
module hs32_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dat,
  input  logic [3:0]  req_sel,
  output logic        resp_valid,
  output logic [31:0] resp_dat,
  output logic        resp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t      state_q;
  logic        ready_q;
  logic        cyc_q;
  logic        we_q;
  logic        valid_q;
  logic [3:0]  sel_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic [31:0] rdat_q;

`ifdef HS32_WBM_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tmo_q;
  logic          err_q;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdat_q  <= '0;
`ifdef HS32_WBM_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // ready rises one edge after reset release, so the first edge never handshakes
          ready_q <= 1'b1;
          if (req_valid && ready_q) begin
            we_q    <= req_we;
            adr_q   <= req_adr;
            dat_q   <= req_dat;
            sel_q   <= req_sel;
            cyc_q   <= 1'b1;
            ready_q <= 1'b0;
            state_q <= BUS;
`ifdef HS32_WBM_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end
        end
        BUS: begin
          if (wbm_ack_i) begin
            if (!we_q) rdat_q <= wbm_dat_i;
            cyc_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= RESP;
`ifdef HS32_WBM_TIMEOUT_EN
            err_q   <= 1'b0;
          end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            // this edge closes BUS cycle number TIMEOUT_CYCLES with no ack
            cyc_q   <= 1'b0;
            valid_q <= 1'b1;
            err_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            tmo_q   <= tmo_q + 1'b1;
`endif
          end
        end
        RESP: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
`ifdef HS32_WBM_TIMEOUT_EN
          err_q   <= 1'b0;
`endif
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          cyc_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_dat   = rdat_q;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = cyc_q;
  assign wbm_we_o   = we_q;
  assign wbm_sel_o  = sel_q;
  assign wbm_adr_o  = adr_q;
  assign wbm_dat_o  = dat_q;
`ifdef HS32_WBM_TIMEOUT_EN
  assign resp_err   = err_q;
`else
  assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_hs32_wb_master.sv
// Directed bench for hs32_wb_master: vector table plus hand sequences for
// back-to-back, mid-cycle reset, spurious ack and timeout behaviour.
module tb_hs32_wb_master;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_adr = '0;
  logic [31:0] req_dat = '0;
  logic [3:0]  req_sel = '0;
  logic        resp_valid;
  logic [31:0] resp_dat;
  logic        resp_err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = 32'h5555_5555;
  logic        wbm_ack_i = 1'b0;

  hs32_wb_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
    .resp_valid(resp_valid), .resp_dat(resp_dat), .resp_err(resp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int resp_cnt = 0;
  int hs_cnt = 0;
  int ovl_cnt = 0;

  always @(posedge clk) begin
    if (resp_valid) resp_cnt++;
    if (req_valid && req_ready) hs_cnt++;
    if (req_ready && wbm_cyc_o) ovl_cnt++;
    if (resp_valid && wbm_stb_o) ovl_cnt++;
    if (wbm_stb_o && !wbm_cyc_o) ovl_cnt++;
  end

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          waits;
    logic [31:0] slave_dat;
    logic [31:0] exp_rdat;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for req_ready, presents one request; returns #1 after the handshake edge.
  task automatic start_req(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic run_xfer(input vec_t v);
    int rc0;
    bit stable;
    start_req(v.we, v.adr, v.dat, v.sel);
    rc0 = resp_cnt;
    check("bus_cyc", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd3);
    check("bus_adr", wbm_adr_o, v.adr);
    check("bus_we",  {31'd0, wbm_we_o}, {31'd0, v.we});
    check("bus_sel", {28'd0, wbm_sel_o}, {28'd0, v.sel});
    check("bus_dat", wbm_dat_o, v.dat);
    check("ready_low_in_bus", {31'd0, req_ready}, 32'd0);
    stable = 1'b1;
    for (int i = 0; i < v.waits; i++) begin
      wbm_dat_i = 32'h5555_5555 + i;
      tick();
      if (!(wbm_cyc_o && wbm_stb_o && wbm_adr_o == v.adr && wbm_we_o == v.we &&
            wbm_sel_o == v.sel && wbm_dat_o == v.dat && !resp_valid)) stable = 1'b0;
    end
    check("bus_stable", {31'd0, stable}, 32'd1);
    wbm_dat_i = v.slave_dat;
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h5555_5555;
    check("cyc_dropped", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    check("resp_valid_hi", {31'd0, resp_valid}, 32'd1);
    check("resp_dat", resp_dat, v.exp_rdat);
    check("resp_err", {31'd0, resp_err}, 32'd0);
    tick();
    check("resp_valid_lo", {31'd0, resp_valid}, 32'd0);
    check("ready_after", {31'd0, req_ready}, 32'd1);
    check("resp_count", resp_cnt - rc0, 32'd1);
  endtask

  initial begin
    int n, rc0, hs0, ov0;
    logic [31:0] held;

    vecs[0] = '{1'b0, 32'h3000_0010, 32'h0000_0000, 4'hF, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h3000_0004, 32'h1234_5678, 4'h3, 5, 32'hA5A5_A5A5, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 32'h3000_0020, 32'hFFFF_FFFF, 4'h1, 2, 32'h0000_00C3, 32'h0000_00C3};
    vecs[3] = '{1'b1, 32'h3000_0008, 32'hCAFE_F00D, 4'hC, 0, 32'h1111_1111, 32'h0000_00C3};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
    check("rst_we_sel", {27'd0, wbm_we_o, wbm_sel_o}, 32'd0);
    check("rst_adr", wbm_adr_o, 32'd0);
    check("rst_dat", wbm_dat_o, 32'd0);
    check("rst_resp_dat", resp_dat, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("ready_first_edge", {31'd0, req_ready}, 32'd1);

    for (int k = 0; k < 4; k++) run_xfer(vecs[k]);

    // Back-to-back: req_valid held for three reads
    hs0 = hs_cnt; rc0 = resp_cnt; ov0 = ovl_cnt;
    req_we = 1'b0; req_adr = 32'h3000_0040; req_sel = 4'hF;
    req_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      n = 0;
      while (!wbm_cyc_o && n < 20) begin tick(); n++; end
      check("b2b_cyc_seen", {31'd0, wbm_cyc_o}, 32'd1);
      if (t == 2) req_valid = 1'b0;
      wbm_dat_i = 32'h100 + t;
      wbm_ack_i = 1'b1;
      tick();
      wbm_ack_i = 1'b0;
      check("b2b_resp_dat", resp_dat, 32'h100 + t);
    end
    req_valid = 1'b0;
    repeat (4) tick();
    check("b2b_handshakes", hs_cnt - hs0, 32'd3);
    check("b2b_resps", resp_cnt - rc0, 32'd3);
    check("b2b_overlap", ovl_cnt - ov0, 32'd0);

    // Spurious ack in IDLE
    rc0 = resp_cnt; held = resp_dat;
    wbm_dat_i = 32'hBAD0_BAD0;
    wbm_ack_i = 1'b1;
    repeat (3) tick();
    wbm_ack_i = 1'b0;
    tick();
    check("idle_ack_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    check("idle_ack_resp", resp_cnt - rc0, 32'd0);
    check("idle_ack_ready", {31'd0, req_ready}, 32'd1);
    check("idle_ack_dat", resp_dat, held);

    // Reset two cycles into BUS
    rc0 = resp_cnt;
    start_req(1'b0, 32'h3000_0080, 32'h0, 4'hF);
    tick();
    tick();
    check("pre_rst_cyc", {31'd0, wbm_cyc_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    check("async_rst_ready", {31'd0, req_ready}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    check("rst_no_resp", resp_cnt - rc0, 32'd0);
    run_xfer('{1'b0, 32'h3000_0084, 32'h0, 4'hF, 1, 32'h0BAD_F00D, 32'h0BAD_F00D});

`ifdef HS32_WBM_TIMEOUT_EN
    // Timeout: no ack, abort after TMO BUS cycles; late ack ignored
    rc0 = resp_cnt; held = resp_dat;
    start_req(1'b0, 32'h3000_0100, 32'h0, 4'hF);
    n = 0;
    while (wbm_cyc_o && n < 50) begin tick(); n++; end
    check("tmo_bus_cycles", n, TMO);
    check("tmo_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("tmo_resp_err", {31'd0, resp_err}, 32'd1);
    check("tmo_resp_dat", resp_dat, held);
    wbm_dat_i = 32'h7777_7777;
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    tick();
    check("tmo_late_ack", resp_cnt - rc0, 32'd1);
    check("tmo_late_dat", resp_dat, held);
    check("tmo_late_cyc", {31'd0, wbm_cyc_o}, 32'd0);

    // Ack on the terminal edge wins over the timeout
    start_req(1'b0, 32'h3000_0104, 32'h0, 4'hF);
    repeat (TMO - 1) tick();
    check("tmo_edge_cyc", {31'd0, wbm_cyc_o}, 32'd1);
    wbm_dat_i = 32'h2468_ACE0;
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    check("tmo_edge_valid", {31'd0, resp_valid}, 32'd1);
    check("tmo_edge_err", {31'd0, resp_err}, 32'd0);
    check("tmo_edge_dat", resp_dat, 32'h2468_ACE0);
    tick();
`else
    // Without timeout support the bus waits indefinitely
    rc0 = resp_cnt;
    start_req(1'b0, 32'h3000_0100, 32'h0, 4'hF);
    repeat (300) tick();
    check("no_tmo_cyc", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd3);
    check("no_tmo_resp", resp_cnt - rc0, 32'd0);
    wbm_dat_i = 32'h1357_9BDF;
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    check("no_tmo_valid", {31'd0, resp_valid}, 32'd1);
    check("no_tmo_err", {31'd0, resp_err}, 32'd0);
    check("no_tmo_dat", resp_dat, 32'h1357_9BDF);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
